// File: rtl/cmem_mp.sv
// cmem_mp: 1-write / NPORT-read coefficient store, zeroed by a DEPTH-cycle clear after reset (busy=1); read latency 2, no backpressure.
// Define CMEM_BYPASS_EN for write-first on a same-cycle read/write address collision; the default is read-first.
module cmem_mp #(
  parameter int DW    = 16,
  parameter int AW    = 6,
  parameter int NPORT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen_n,
  input  logic                wen_n,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       d,
  input  logic [NPORT*AW-1:0] ra,
  output logic [NPORT*DW-1:0] q,
  output logic                q_vld,
  output logic                busy
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] clr_addr_nxt;
  logic          mem_clr;

  // stage-1 registered request
  logic                wr_en_r;
  logic                rd_en_r;
  logic [AW-1:0]       wa_r;
  logic [DW-1:0]       d_r;
  logic [NPORT*AW-1:0] ra_r;

  logic [DW-1:0]       mem [DEPTH];
  logic [NPORT*DW-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    busy         = 1'b0;
    mem_clr      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy         = 1'b1;
        mem_clr      = 1'b1;
        clr_addr_nxt = clr_addr + ADDR_ONE;
        if (clr_addr == ADDR_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt    = ST_CLEAR;
        clr_addr_nxt = '0;
      end
    endcase
  end

  // Requests arriving during the clear are dropped by forcing the enables low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;
      wa_r    <= '0;
      d_r     <= '0;
      ra_r    <= '0;
    end else if (busy) begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;
    end else begin
      wr_en_r <= ~cen_n & ~wen_n;
      rd_en_r <= ~cen_n;
      if (!cen_n) begin
        wa_r <= wa;
        d_r  <= d;
        ra_r <= ra;
      end
    end
  end

  // Array has no reset; the clear sequence owns the write port while busy.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      mem[clr_addr] <= '0;
    end else if (wr_en_r) begin
      mem[wa_r] <= d_r;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      rd_data[i*DW +: DW] = mem[ra_r[i*AW +: AW]];
`ifdef CMEM_BYPASS_EN
      if (wr_en_r && (ra_r[i*AW +: AW] == wa_r)) begin
        rd_data[i*DW +: DW] = d_r;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= rd_en_r;
      if (rd_en_r) begin
        q <= rd_data;
      end
    end
  end

endmodule
